// File: rtl/rhs_pkg.sv
// Shared definitions for the RHS headstage SPI capture path.
package rhs_pkg;

    localparam int RHS_WORD_BITS = 32;
    localparam int RHS_NUM_PORTS = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } rhs_state_e;

endpackage

// File: rtl/rhs_miso_port_sampler.sv
// One port's MISO sampler: saturated offset, bit-index match, shift register.
module rhs_miso_port_sampler #(
    parameter int WORD_BITS    = 32,
    parameter int CLKS_PER_BIT = 4,
    parameter int OFFSET_W     = 8,
    parameter int MAX_OFFSET   = 15,
    parameter int T_W          = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 capture,
    input  logic [T_W-1:0]       t,
    input  logic                 miso,
    input  logic [OFFSET_W-1:0]  offset,
    output logic [WORD_BITS-1:0] word
);

    localparam int BI_W = $clog2(WORD_BITS + 1);

    logic [OFFSET_W-1:0] off_sat;
    logic [OFFSET_W-1:0] off_q;
    logic [BI_W-1:0]     bidx;
    logic [31:0]         tgt;
    logic                hit;

    // Next sample lands on bit bidx's slot shifted by this port's delay
    always_comb begin
        off_sat = offset;
        if (offset > OFFSET_W'(MAX_OFFSET))
            off_sat = OFFSET_W'(MAX_OFFSET);
        tgt = 32'(bidx) * 32'(CLKS_PER_BIT) + 32'(off_q);
        hit = capture
            && (bidx < BI_W'(WORD_BITS))
            && (32'(t) == tgt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            off_q <= '0;
            bidx  <= '0;
            word  <= '0;
        end else if (load) begin
            off_q <= off_sat;
            bidx  <= '0;
            word  <= '0;
        end else if (hit) begin
            word <= {word[WORD_BITS-2:0], miso};
            bidx <= bidx + 1'b1;
        end
    end

endmodule

// File: rtl/rhs_miso_capture_n.sv
// Multi-port MISO capture engine: per-port offset sampling, one word per port per frame.
module rhs_miso_capture_n
    import rhs_pkg::*;
#(
    parameter int NUM_PORTS    = RHS_NUM_PORTS,
    parameter int WORD_BITS    = RHS_WORD_BITS,
    parameter int CLKS_PER_BIT = 4,
    parameter int OFFSET_W     = 8,
    parameter int MAX_OFFSET   = 15,
    parameter int CH_W         = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           frame_start,
    input  logic [CH_W-1:0]                frame_channel,
    input  logic [NUM_PORTS-1:0]           miso,
    input  logic [NUM_PORTS*OFFSET_W-1:0]  oversample_offset,
    output logic [NUM_PORTS*WORD_BITS-1:0] data_out,
    output logic [CH_W-1:0]                data_channel,
    output logic                           data_valid,
    output logic                           busy,
    output logic                           overrun,
    input  logic                           clear_overrun
);

    localparam int T_END = WORD_BITS * CLKS_PER_BIT + MAX_OFFSET - 1;
    localparam int T_W   = $clog2(T_END + 1);

    rhs_state_e                     state;
    logic [T_W-1:0]                 t;
    logic [CH_W-1:0]                tag_q;
    logic [NUM_PORTS*WORD_BITS-1:0] words;
    logic                           capture;
    logic                           load;

    assign capture = (state == CAPTURE);
    assign load    = frame_start && !capture;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        rhs_miso_port_sampler #(
            .WORD_BITS    (WORD_BITS),
            .CLKS_PER_BIT (CLKS_PER_BIT),
            .OFFSET_W     (OFFSET_W),
            .MAX_OFFSET   (MAX_OFFSET),
            .T_W          (T_W)
        ) u_smp (
            .clk     (clk),
            .rst     (rst),
            .load    (load),
            .capture (capture),
            .t       (t),
            .miso    (miso[p]),
            .offset  (oversample_offset[p*OFFSET_W +: OFFSET_W]),
            .word    (words[p*WORD_BITS +: WORD_BITS])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            t            <= '0;
            tag_q        <= '0;
            data_out     <= '0;
            data_channel <= '0;
            data_valid   <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            // Set is evaluated last so it wins over a same-cycle clear
            if (clear_overrun)
                overrun <= 1'b0;
            if (frame_start && capture)
                overrun <= 1'b1;
            unique case (state)
                IDLE, DONE: begin
                    if (frame_start) begin
                        state <= CAPTURE;
                        t     <= '0;
                        tag_q <= frame_channel;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                CAPTURE: begin
                    if (t == T_W'(T_END)) begin
                        state        <= DONE;
                        busy         <= 1'b0;
                        data_out     <= words;
                        data_channel <= tag_q;
                        data_valid   <= 1'b1;
                    end else begin
                        t <= t + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rhs_miso_capture_n.sv
// Scoreboard bench for rhs_miso_capture_n with per-port delayed slave models.
module tb_rhs_miso_capture_n;

    localparam int NP  = 16;
    localparam int WB  = 32;
    localparam int CPB = 4;
    localparam int OW  = 8;
    localparam int MO  = 15;
    localparam int CW  = 8;
    localparam int LAT = WB * CPB + MO + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              frame_start;
    logic [CW-1:0]     frame_channel;
    logic [NP-1:0]     miso;
    logic [NP*OW-1:0]  oversample_offset;
    logic [NP*WB-1:0]  data_out;
    logic [CW-1:0]     data_channel;
    logic              data_valid;
    logic              busy;
    logic              overrun;
    logic              clear_overrun;

    typedef struct {
        int unsigned      cs;
        logic [CW-1:0]    tag;
        logic [NP*WB-1:0] w;
    } exp_t;

    exp_t          sb[$];
    logic [WB-1:0] mword [NP];
    int            mdelay [NP];
    logic [OW-1:0] moff [NP];
    int unsigned   cyc;
    int            fc;
    int            nvalid;
    int            nchk;
    int            npass;

    rhs_miso_capture_n dut (
        .clk               (clk),
        .rst               (rst),
        .frame_start       (frame_start),
        .frame_channel     (frame_channel),
        .miso              (miso),
        .oversample_offset (oversample_offset),
        .data_out          (data_out),
        .data_channel      (data_channel),
        .data_valid        (data_valid),
        .busy              (busy),
        .overrun           (overrun),
        .clear_overrun     (clear_overrun)
    );

    always #5 clk = ~clk;

    always_comb begin
        oversample_offset = '0;
        for (int p = 0; p < NP; p++)
            oversample_offset[p*OW +: OW] = moff[p];
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        nchk++;
        if (got === exp)
            npass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Slave p drives bit b during frame cycles 1+d+CPB*b .. CPB+d+CPB*b
    function automatic logic model_bit(input int p, input int c);
        int b;
        if (c < 1 + mdelay[p] || c > WB * CPB + mdelay[p])
            return 1'b0;
        b = (c - 1 - mdelay[p]) / CPB;
        return mword[p][WB-1-b];
    endfunction

    task automatic drive_miso();
        for (int p = 0; p < NP; p++)
            miso[p] = model_bit(p, fc);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        frame_start   = 1'b0;
        clear_overrun = 1'b0;
        cyc++;
        fc++;
        if (data_valid) begin
            nvalid++;
            if (sb.size() == 0) begin
                chk("spurious_valid", 64'(data_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("latency", 64'(cyc - e.cs), 64'(LAT));
                chk("tag", 64'(data_channel), 64'(e.tag));
                for (int p = 0; p < NP; p++)
                    chk($sformatf("word%0d", p),
                        64'(data_out[p*WB +: WB]),
                        64'(e.w[p*WB +: WB]));
            end
        end
        drive_miso();
    endtask

    task automatic start_frame(input logic [CW-1:0] tag);
        exp_t e;
        int   o;
        frame_start   = 1'b1;
        frame_channel = tag;
        fc = 0;
        drive_miso();
        e.cs  = cyc;
        e.tag = tag;
        e.w   = '0;
        for (int p = 0; p < NP; p++) begin
            o = (int'(moff[p]) > MO) ? MO : int'(moff[p]);
            for (int b = 0; b < WB; b++)
                e.w[p*WB + WB - 1 - b] = model_bit(p, 1 + CPB * b + o);
        end
        sb.push_back(e);
    endtask

    task automatic wait_valid();
        int n0;
        n0 = nvalid;
        for (int i = 0; i < 400 && nvalid == n0; i++)
            tick();
        chk("valid_seen", 64'(nvalid - n0), 64'd1);
    endtask

    task automatic set_ports(input int delay, input logic [OW-1:0] off);
        for (int p = 0; p < NP; p++) begin
            mword[p]  = 32'hA5A50000 | 32'(p);
            mdelay[p] = delay;
            moff[p]   = off;
        end
    endtask

    initial begin
        nchk = 0; npass = 0; nvalid = 0; cyc = 0; fc = 1000;
        rst = 1'b1;
        frame_start = 1'b0;
        frame_channel = '0;
        clear_overrun = 1'b0;
        miso = '0;
        set_ports(0, 8'd0);
        repeat (3) tick();
        chk("rst_valid", 64'(data_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        chk("rst_chan", 64'(data_channel), 64'd0);
        chk("rst_data", 64'(|data_out), 64'd0);
        rst = 1'b0;
        tick();

        // Aligned ports
        start_frame(8'h12);
        tick();
        chk("busy_cap", 64'(busy), 64'd1);
        wait_valid();
        chk("busy_done", 64'(busy), 64'd0);

        // Delayed port 3, compensated then not compensated
        mdelay[3] = 5;
        moff[3]   = 8'd5;
        tick();
        start_frame(8'h23);
        wait_valid();
        moff[3] = 8'd0;
        tick();
        start_frame(8'h24);
        wait_valid();

        // Offset saturation
        set_ports(0, 8'd0);
        mdelay[0] = 15;
        moff[0]   = 8'd200;
        mword[0]  = 32'h3C96F00D;
        tick();
        start_frame(8'h35);
        wait_valid();

        // Back-to-back frames started in the DONE cycle
        set_ports(0, 8'd0);
        tick();
        for (int k = 0; k < 10; k++) begin
            for (int p = 0; p < NP; p++) begin
                mword[p]  = $urandom;
                mdelay[p] = p % 4;
                moff[p]   = OW'(p % 4);
            end
            start_frame(CW'(k));
            wait_valid();
        end
        chk("b2b_overrun", 64'(overrun), 64'd0);

        // Overrun set, clear, and set-over-clear priority
        tick();
        start_frame(8'h51);
        repeat (50) tick();
        frame_start = 1'b1;
        tick();
        chk("ovr_set", 64'(overrun), 64'd1);
        chk("ovr_busy", 64'(busy), 64'd1);
        wait_valid();
        clear_overrun = 1'b1;
        tick();
        chk("ovr_clear", 64'(overrun), 64'd0);
        start_frame(8'h52);
        repeat (20) tick();
        frame_start = 1'b1;
        tick();
        chk("ovr_set2", 64'(overrun), 64'd1);
        frame_start   = 1'b1;
        clear_overrun = 1'b1;
        tick();
        chk("ovr_prio", 64'(overrun), 64'd1);
        wait_valid();

        // Reset mid-frame
        start_frame(8'h66);
        repeat (61) tick();
        chk("pre_rst_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        sb.delete();
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_ovr", 64'(overrun), 64'd0);
        chk("mid_rst_chan", 64'(data_channel), 64'd0);
        chk("mid_rst_data", 64'(|data_out), 64'd0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (200) tick();
        set_ports(2, 8'd2);
        start_frame(8'h77);
        wait_valid();
        repeat (5) tick();
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
